// File: rtl/fib_sched_pkg.sv
// Shared types and constants for the Fibonacci engine scheduler.
//   state_t       scheduler FSM states
//   FIB_MAX_N_32  largest n whose F(n) fits in 32 bits (F(0)=0, F(1)=1)
package fib_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int unsigned FIB_MAX_N_32 = 47;

endpackage

// File: rtl/fib_engine_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps,
// and the first asserted request wins.
//   req  in  N      request vector
//   ptr  in  PTR_W  index where the search starts
//   gnt  out N      one-hot grant (all zero when no request)
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  // Walk the requests starting at ptr; the first hit is granted.
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = PTR_W'((32'(ptr) + k) % N);
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fib_engine_scheduler.sv
// Shares one Fibonacci engine between NUM_REQ requesters. Round-robin
// arbitration, one job at a time; results are returned on a valid/ready
// channel tagged with the requester id.
// Optional build macro: FIB_SCHED_RANGE_CHECK_EN (n > MAX_N answered with
// rsp_err=1 and rsp_data=0 without running the engine).
//   clk, reset              clock, synchronous active-high reset
//   req_valid/req_n/ready   per-requester request channel (ready = one-hot grant)
//   eng_start/eng_n         one-cycle start pulse and index to the engine
//   eng_done/eng_result     engine completion and F(n)
//   rsp_valid/ready/id/data/err  response channel
module fib_engine_scheduler
  import fib_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned N_W     = 7,
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned MAX_N   = FIB_MAX_N_32,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*N_W-1:0] req_n,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   eng_start,
  output logic [N_W-1:0]         eng_n,
  input  logic                   eng_done,
  input  logic [DATA_W-1:0]      eng_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err
);

  state_t              r_state, w_state_nxt;
  logic [ID_W-1:0]     r_ptr, w_ptr_nxt;
  logic                r_eng_start, w_eng_start_nxt;
  logic [N_W-1:0]      r_eng_n, w_eng_n_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [ID_W-1:0]     r_rsp_id, w_rsp_id_nxt;
  logic [DATA_W-1:0]   r_rsp_data, w_rsp_data_nxt;
  logic                r_rsp_err, w_rsp_err_nxt;

  logic [NUM_REQ-1:0]  w_gnt;
  logic                w_grant_en;
  logic                w_accept;
  logic [ID_W-1:0]     w_win_id;
  logic [N_W-1:0]      w_win_n;
  logic                w_out_of_range;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  // Grants are offered only in IDLE and never while reset is applied.
  assign w_grant_en = (r_state == IDLE) && !reset;
  assign req_ready  = w_grant_en ? w_gnt : '0;
  assign w_accept   = w_grant_en && (|w_gnt);

  // Encode the one-hot winner and pick its slice of req_n.
  always_comb begin
    w_win_id = '0;
    w_win_n  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_win_id = ID_W'(i);
        w_win_n  = req_n[i*N_W +: N_W];
      end
    end
  end

`ifdef FIB_SCHED_RANGE_CHECK_EN
  assign w_out_of_range = (32'(w_win_n) > MAX_N);
`else
  assign w_out_of_range = 1'b0;
  // MAX_N only matters when the range check is built in.
  if (MAX_N == 0) begin : g_max_n_unused
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_eng_start_nxt = 1'b0;
    w_eng_n_nxt     = r_eng_n;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_id_nxt    = r_rsp_id;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_ptr_nxt    = (w_win_id == ID_W'(NUM_REQ - 1)) ? '0 : w_win_id + ID_W'(1);
          w_rsp_id_nxt = w_win_id;
          if (w_out_of_range) begin
            // Skip the engine and answer straight away with an error.
            w_state_nxt     = RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_data_nxt  = '0;
            w_rsp_err_nxt   = 1'b1;
          end else begin
            w_state_nxt     = ISSUE;
            w_eng_start_nxt = 1'b1;
            w_eng_n_nxt     = w_win_n;
            w_rsp_err_nxt   = 1'b0;
          end
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (eng_done) begin
          w_state_nxt     = RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = eng_result;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = IDLE;
          w_rsp_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_eng_start <= 1'b0;
      r_eng_n     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_eng_start <= w_eng_start_nxt;
      r_eng_n     <= w_eng_n_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_id    <= w_rsp_id_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign eng_start = r_eng_start;
  assign eng_n     = r_eng_n;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule
